// File: rtl/ctrl_div_pkg.sv
// Shared definitions for the shift/subtract divider control: state codes,
// default width, iteration-counter width and the Moore output decode.
package ctrl_div_pkg;

    localparam int unsigned N_DEF  = 16;
    localparam int unsigned ITER_W = 5;

    typedef enum logic [2:0] {
        INICIO   = 3'b000,
        CARGA    = 3'b001,
        DESPLAZA = 3'b010,
        EVALUA   = 3'b011,
        FIN      = 3'b100,
        ERROR    = 3'b101
    } estado_t;

    typedef struct packed {
        logic cargar;
        logic desplazar;
        logic bit_valido;
        logic ocupado;
        logic hecho;
        logic error_div0;
    } ctrl_t;

    // Moore strobes as a function of state only
    function automatic ctrl_t decodificar(estado_t e);
        ctrl_t c;
        c = '0;
        case (e)
            CARGA:    begin c.cargar     = 1'b1; c.ocupado = 1'b1; end
            DESPLAZA: begin c.desplazar  = 1'b1; c.ocupado = 1'b1; end
            EVALUA:   begin c.bit_valido = 1'b1; c.ocupado = 1'b1; end
            FIN:      c.hecho      = 1'b1;
            ERROR:    c.error_div0 = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/secuenciador_divisor_contador_iter.sv
// Iteration counter: loadable down-counter that saturates at zero.
module contador_iter
    import ctrl_div_pkg::*;
(
    input  logic              reloj,
    input  logic              reset,
    input  logic              cargar_i,
    input  logic              decrementar_i,
    input  logic [ITER_W-1:0] valor_i,
    output logic [ITER_W-1:0] cuenta_o,
    output logic              cero_o
);

    logic [ITER_W-1:0] cuenta_q;
    logic [ITER_W-1:0] cuenta_d;

    // Load has priority; decrement only while nonzero so the count never wraps
    always_comb begin
        cuenta_d = cuenta_q;
        if (cargar_i) begin
            cuenta_d = valor_i;
        end else if (decrementar_i && (cuenta_q != '0)) begin
            cuenta_d = cuenta_q - 1'b1;
        end
    end

    // Count register, falling-edge clocked with asynchronous clear
    always_ff @(negedge reloj or negedge reset) begin
        if (!reset) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign cuenta_o = cuenta_q;
    assign cero_o   = (cuenta_q == '0);

endmodule

// File: rtl/secuenciador_divisor.sv
// Control sequencer for a restoring shift/subtract divider. Sequences
// load, N shift/evaluate pairs, then holds the done or div-by-zero flag
// until the host drops go.
module secuenciador_divisor
    import ctrl_div_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic              reloj,
    input  logic              reset,
    input  logic              go,
    input  logic              divisor_no_cero,
    input  logic              residuo_ge,
    output logic              cargar,
    output logic              desplazar,
    output logic              restar,
    output logic              bit_q,
    output logic              bit_valido,
    output logic              ocupado,
    output logic              hecho,
    output logic              error_div0,
    output logic [2:0]        est,
    output logic [ITER_W-1:0] iter
);

    localparam logic [ITER_W-1:0] ITER_INI = ITER_W'(N - 1);

    estado_t           estado_q;
    estado_t           estado_d;
    ctrl_t             ctrl_q;
    logic              iter_cero;
    logic              en_carga;
    logic              en_evalua;

    assign en_carga  = (estado_q == CARGA);
    assign en_evalua = (estado_q == EVALUA);

    // Next-state logic; go/divisor_no_cero only matter in the waiting states
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIO:   if (go) estado_d = divisor_no_cero ? CARGA : ERROR;
            CARGA:    estado_d = DESPLAZA;
            DESPLAZA: estado_d = EVALUA;
            EVALUA:   estado_d = iter_cero ? FIN : DESPLAZA;
            FIN:      if (!go) estado_d = INICIO;
            ERROR:    if (!go) estado_d = INICIO;
            default:  estado_d = INICIO;
        endcase
    end

    // State and Moore outputs; outputs decode the next state so that the
    // registered copy always equals the decode of the present state
    always_ff @(negedge reloj or negedge reset) begin
        if (!reset) begin
            estado_q <= INICIO;
            ctrl_q   <= '0;
        end else begin
            estado_q <= estado_d;
            ctrl_q   <= decodificar(estado_d);
        end
    end

    contador_iter u_contador_iter (
        .reloj         (reloj),
        .reset         (reset),
        .cargar_i      (en_carga),
        .decrementar_i (en_evalua),
        .valor_i       (ITER_INI),
        .cuenta_o      (iter),
        .cero_o        (iter_cero)
    );

    assign cargar     = ctrl_q.cargar;
    assign desplazar  = ctrl_q.desplazar;
    assign bit_valido = ctrl_q.bit_valido;
    assign ocupado    = ctrl_q.ocupado;
    assign hecho      = ctrl_q.hecho;
    assign error_div0 = ctrl_q.error_div0;
    assign restar     = en_evalua & residuo_ge;
    assign bit_q      = en_evalua & residuo_ge;
    assign est        = estado_q;

endmodule

// File: tb/tb_secuenciador_divisor.sv
// Directed bench for secuenciador_divisor with a 16-bit restoring-divider
// datapath model, plus a second N=2 instance.
module tb_secuenciador_divisor;

    logic       reloj = 1'b1;
    logic       reset = 1'b0;
    logic       go = 1'b0;
    logic       force_ge = 1'b0;
    logic [15:0] dvd_in = '0;
    logic [15:0] dvs_reg = '0;
    logic [15:0] q_m = '0;
    logic [16:0] r_m = '0;

    logic       divisor_no_cero, residuo_ge;
    logic       cargar, desplazar, restar, bit_q, bit_valido, ocupado, hecho, error_div0;
    logic [2:0] est;
    logic [4:0] iter;

    logic       go2 = 1'b0;
    logic       cargar2, desplazar2, restar2, bit_q2, bit_valido2, ocupado2, hecho2, error2;
    logic [2:0] est2;
    logic [4:0] iter2;

    int checks = 0;
    int errors = 0;

    int n_cargar, n_desp, n_bv, n_restar, n_bitq, alt_err, dec_err, it2_err;
    int ultimo; // 1 = last strobe was desplazar, 2 = bit_valido

    always #5 reloj = ~reloj;

    assign divisor_no_cero = (dvs_reg != 16'd0);
    assign residuo_ge      = force_ge | (r_m >= {1'b0, dvs_reg});

    secuenciador_divisor #(.N(16)) dut (
        .reloj(reloj), .reset(reset), .go(go), .divisor_no_cero(divisor_no_cero),
        .residuo_ge(residuo_ge), .cargar(cargar), .desplazar(desplazar), .restar(restar),
        .bit_q(bit_q), .bit_valido(bit_valido), .ocupado(ocupado), .hecho(hecho),
        .error_div0(error_div0), .est(est), .iter(iter)
    );

    secuenciador_divisor #(.N(2)) dut2 (
        .reloj(reloj), .reset(reset), .go(go2), .divisor_no_cero(1'b1),
        .residuo_ge(1'b0), .cargar(cargar2), .desplazar(desplazar2), .restar(restar2),
        .bit_q(bit_q2), .bit_valido(bit_valido2), .ocupado(ocupado2), .hecho(hecho2),
        .error_div0(error2), .est(est2), .iter(iter2)
    );

    // Datapath model: reacts to strobes present before each falling edge
    always @(negedge reloj) begin
        if (cargar) begin
            q_m <= dvd_in;
            r_m <= '0;
        end else if (desplazar) begin
            {r_m, q_m} <= {r_m[15:0], q_m, 1'b0};
        end else if (bit_valido) begin
            q_m[0] <= bit_q;
            if (restar) r_m <= r_m - {1'b0, dvs_reg};
        end
    end

    // Mid-cycle monitor: strobe counts, alternation, state/output decode
    always @(posedge reloj) begin
        if (cargar) begin n_cargar++; ultimo = 2; end
        if (desplazar) begin
            n_desp++;
            if (ultimo == 1) alt_err++;
            ultimo = 1;
        end
        if (bit_valido) begin
            n_bv++;
            if (ultimo != 1) alt_err++;
            ultimo = 2;
        end
        if (restar) n_restar++;
        if (bit_q) n_bitq++;
        if (cargar     !== (est == 3'd1)) dec_err++;
        if (desplazar  !== (est == 3'd2)) dec_err++;
        if (bit_valido !== (est == 3'd3)) dec_err++;
        if (ocupado    !== (est == 3'd1 || est == 3'd2 || est == 3'd3)) dec_err++;
        if (hecho      !== (est == 3'd4)) dec_err++;
        if (error_div0 !== (est == 3'd5)) dec_err++;
        if (est != 3'd3 && (restar || bit_q)) dec_err++;
        if (iter2 > 5'd1) it2_err++;
    end

    task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic limpiar();
        n_cargar = 0; n_desp = 0; n_bv = 0; n_restar = 0; n_bitq = 0;
        alt_err = 0; dec_err = 0;
    endtask

    function automatic logic [31:0] salidas();
        return {24'd0, cargar, desplazar, restar, bit_q, bit_valido, ocupado, hecho, error_div0};
    endfunction

    // Start a division on the N=16 instance and wait (bounded) for hecho
    task automatic dividir(input logic [15:0] dd, input logic [15:0] dv, input string tag);
        int k;
        limpiar();
        dvd_in = dd;
        dvs_reg = dv;
        @(posedge reloj); #1 go = 1'b1;
        @(negedge reloj); #1;
        chequear({tag, "_carga"}, est, 3'd1);
        k = 0;
        while (!hecho && k < 100) begin
            @(negedge reloj); #1;
            k++;
            if (k == 2) chequear({tag, "_iter_ini"}, iter, 5'd15);
        end
        chequear({tag, "_latencia"}, k, 33);
        chequear({tag, "_n_bv"}, n_bv, 16);
        chequear({tag, "_n_desp"}, n_desp, 16);
        chequear({tag, "_n_cargar"}, n_cargar, 1);
        chequear({tag, "_alternancia"}, alt_err, 0);
        chequear({tag, "_decode"}, dec_err, 0);
    endtask

    initial begin
        int k;
        int bajos;
        limpiar();
        ultimo = 2;
        it2_err = 0;

        // Reset state
        @(negedge reloj); @(negedge reloj); #1;
        chequear("rst_est", est, 3'd0);
        chequear("rst_iter", iter, 5'd0);
        chequear("rst_salidas", salidas(), 0);
        @(posedge reloj); #1 reset = 1'b1;
        @(negedge reloj); #1;
        chequear("idle_est", est, 3'd0);

        // 100 / 7 = 14 r 2 (quotient 1110b -> three subtractions)
        dividir(16'd100, 16'd7, "d100_7");
        chequear("d100_7_cociente", q_m, 16'd14);
        chequear("d100_7_residuo", r_m, 17'd2);
        chequear("d100_7_n_restar", n_restar, 3);
        chequear("d100_7_n_bitq", n_bitq, 3);

        // go held through FIN: no restart, hecho stays up
        bajos = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge reloj); #1;
            if (!hecho) bajos++;
        end
        chequear("fin_hecho_bajo", bajos, 0);
        chequear("fin_est", est, 3'd4);
        chequear("fin_sin_carga", n_cargar, 1);
        @(posedge reloj); #1 go = 1'b0;
        @(negedge reloj); #1;
        chequear("fin_a_inicio", est, 3'd0);
        chequear("fin_hecho_cae", hecho, 1'b0);

        // Division by zero
        limpiar();
        dvs_reg = 16'd0;
        @(posedge reloj); #1 go = 1'b1;
        @(negedge reloj); #1;
        chequear("div0_est", est, 3'd5);
        chequear("div0_flag", error_div0, 1'b1);
        repeat (3) @(negedge reloj);
        #1;
        chequear("div0_flag_sostenido", error_div0, 1'b1);
        chequear("div0_cargar", n_cargar, 0);
        chequear("div0_desplazar", n_desp, 0);
        @(posedge reloj); #1 go = 1'b0;
        @(negedge reloj); #1;
        chequear("div0_a_inicio", est, 3'd0);

        // Reset between edges 9 and 10 of a division
        dvd_in = 16'd65535;
        dvs_reg = 16'd1;
        @(posedge reloj); #1 go = 1'b1;
        @(negedge reloj); #1 go = 1'b0;
        repeat (9) @(negedge reloj);
        #3 reset = 1'b0;
        #1;
        chequear("rst_medio_est", est, 3'd0);
        chequear("rst_medio_iter", iter, 5'd0);
        chequear("rst_medio_salidas", salidas(), 0);
        @(posedge reloj); #1 reset = 1'b1;
        repeat (3) @(negedge reloj);
        #1;
        chequear("rst_espera_inicio", est, 3'd0);
        dividir(16'd65535, 16'd1, "d65535_1");
        chequear("d65535_1_cociente", q_m, 16'd65535);
        chequear("d65535_1_residuo", r_m, 17'd0);
        @(posedge reloj); #1 go = 1'b0;
        @(negedge reloj);

        // residuo_ge forced high in every evaluation
        force_ge = 1'b1;
        dividir(16'd0, 16'd5, "ge_forzado");
        chequear("ge_forzado_n_restar", n_restar, 16);
        chequear("ge_forzado_n_bitq", n_bitq, 16);
        @(posedge reloj); #1 go = 1'b0; force_ge = 1'b0;
        @(negedge reloj); #1;

        // N=2 instance: hecho after 5 edges, iter 1 then 0
        @(posedge reloj); #1 go2 = 1'b1;
        @(negedge reloj); #1;
        chequear("n2_carga", est2, 3'd1);
        k = 0;
        while (!hecho2 && k < 50) begin
            @(negedge reloj); #1;
            k++;
            if (k == 2) chequear("n2_iter_eval1", iter2, 5'd1);
            if (k == 4) chequear("n2_iter_eval2", iter2, 5'd0);
        end
        chequear("n2_latencia", k, 5);
        @(posedge reloj); #1 go2 = 1'b0;
        @(negedge reloj); #1;
        chequear("n2_a_inicio", est2, 3'd0);
        chequear("n2_iter_rango", it2_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got %0d checks expected completion", checks);
        $fatal(1);
    end

endmodule

// File: doc/secuenciador_divisor.md
SECUENCIADOR_DIVISOR -- requirements
Module: secuenciador_divisor

Interface
REQ-001 Parameter N, default 16, dividend/quotient width and iteration count; legal range 2..32.
REQ-002 reloj  input  1  sole clock; all state changes on falling edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 go  input  1  start request from host; level-sensitive handshake.
REQ-005 divisor_no_cero  input  1  datapath flag, divisor register nonzero.
REQ-006 residuo_ge  input  1  datapath comparator, partial remainder >= divisor.
REQ-007 cargar  output  1  load dividend/divisor into datapath, clear remainder.
REQ-008 desplazar  output  1  shift {remainder,quotient} left one bit.
REQ-009 restar  output  1  write remainder minus divisor into remainder register.
REQ-010 bit_q  output  1  quotient bit value to insert at LSB.
REQ-011 bit_valido  output  1  strobe, bit_q is to be written this cycle.
REQ-012 ocupado  output  1  division in progress.
REQ-013 hecho  output  1  result valid in datapath.
REQ-014 error_div0  output  1  division by zero detected.
REQ-015 est  output  3  present state code.
REQ-016 iter  output  5  remaining iterations minus one.

Function
REQ-017 States SHALL be encoded: INICIO 000, CARGA 001, DESPLAZA 010, EVALUA 011, FIN 100, ERROR 101; codes 110/111 SHALL go to INICIO on the next edge.
REQ-018 INICIO: go=1 and divisor_no_cero=1 -> CARGA; go=1 and divisor_no_cero=0 -> ERROR; otherwise stay.
REQ-019 CARGA: cargar=1 for exactly one cycle; iter loaded with N-1; -> DESPLAZA.
REQ-020 DESPLAZA: desplazar=1 for one cycle; -> EVALUA.
REQ-021 EVALUA: bit_valido=1; bit_q=residuo_ge; restar=residuo_ge (Mealy, same cycle); iter=0 -> FIN, else iter decrements, -> DESPLAZA.
REQ-022 FIN: hecho=1 held until go=0, then -> INICIO; go kept high never restarts a division.
REQ-023 ERROR: error_div0=1 held until go=0, then -> INICIO; no datapath strobe asserted.
REQ-024 ocupado SHALL be 1 exactly in CARGA, DESPLAZA, EVALUA.
REQ-025 All outputs except restar/bit_q SHALL be pure decodes of state (Moore); restar and bit_q SHALL be 0 outside EVALUA.
REQ-026 Latency: hecho SHALL rise 2N+1 falling edges after the edge sampling go in INICIO (33 for N=16).
REQ-027 Exactly N bit_valido strobes and N desplazar strobes SHALL occur per division, alternating, desplazar first.
REQ-028 go and divisor_no_cero SHALL be ignored outside INICIO, FIN, ERROR.
REQ-029 iter SHALL not wrap: decrement occurs only when iter>0.

Reset
REQ-030 reset=0 SHALL immediately force est=000, iter=0, all control strobes, hecho, error_div0, ocupado to 0, regardless of reloj.
REQ-031 Reset asserted mid-division SHALL abandon it; after release the block waits in INICIO for a new go=1 edge-sample.

Structure
REQ-032 State codes, N default and iter width SHALL live in a shared package/include ctrl_div_pkg, reused by the datapath bench.
REQ-033 Iteration counter SHALL be a separate sub-module contador_iter (load, decrement, zero flag, async active-low reset, falling edge).

Verification
REQ-034 N=16, 100/7 datapath model, go pulse held -> hecho at edge 33, quotient 14, remainder 2, 16 bit_valido strobes.
REQ-035 divisor_no_cero=0, go=1 -> ERROR next edge, error_div0=1, zero cargar/desplazar; go=0 -> INICIO.
REQ-036 go held high through FIN for 10 cycles -> hecho stays 1, no second CARGA; go=0 -> est=000 next edge.
REQ-037 reset=0 at edge 9 of a division (between edges) -> outputs 0 before next edge; restart yields correct 65535/1 = 65535.
REQ-038 residuo_ge forced 1 every EVALUA -> restar and bit_q high exactly 16 cycles, never outside EVALUA.
REQ-039 N=2 instance -> hecho after 5 edges, iter never below 0.
